vmproj_page_mem: RTL and testbench

VMPROJ_PAGE_MEM -- requirements
Module: vmproj_page_mem

---
 rtl/vmproj_page_mem.sv | 146 ++++++++++++++
 tb/tb_vmproj_page_mem.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vmproj_page_mem.sv
// rtl/vmproj_page_mem.sv - paged VM projection word store with per-page entry-count check
//
// Purpose:
//   Simple dual-port RAM holding NUM_PAGES pages of PAGE_DEPTH projection words.
//   The producer writes words and then commits a per-page entry count. Each page
//   has a saturating counter of the words actually written to it. A committed
//   count that differs from that counter sets a sticky count_err flag.
//   Committing a count clears the page counter, which closes the page.
//
// Build option:
//   VMPROJ_MEM_OUTREG_EN - adds an output register after the RAM read stage, so
//                          read latency becomes 2 cycles. The extra register
//                          resets to 0.
//
// Ports:
//   clk                        - single clock, all logic on the rising edge
//   reset                      - synchronous, active-high
//   dataarray_data_V_wea       - write enable
//   dataarray_data_V_writeaddr - {page, index} write address
//   dataarray_data_V_din       - write data
//   nentries_0/1_V_we          - entry-count commit strobe for page 0/1
//   nentries_0/1_V_din         - entry count for page 0/1
//   dataarray_data_V_enb       - read enable
//   dataarray_data_V_readaddr  - {page, index} read address
//   dataarray_data_V_dout      - read data; holds its value while no read is issued
//   nentries_0/1_V_dout        - registered entry count of page 0/1
//   count_err                  - sticky count mismatch flag, cleared only by reset
//
// The port list carries one count strobe/data pair per page for the two-page
// configuration.

module vmproj_page_mem #(
  parameter int DATA_WIDTH = 21,
  parameter int NUM_PAGES  = 2,
  parameter int PAGE_DEPTH = 128,
  localparam int ADDR_WIDTH = $clog2(NUM_PAGES * PAGE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dataarray_data_V_wea,
  input  logic [ADDR_WIDTH-1:0] dataarray_data_V_writeaddr,
  input  logic [DATA_WIDTH-1:0] dataarray_data_V_din,
  input  logic                  nentries_0_V_we,
  input  logic [7:0]            nentries_0_V_din,
  input  logic                  nentries_1_V_we,
  input  logic [7:0]            nentries_1_V_din,
  input  logic                  dataarray_data_V_enb,
  input  logic [ADDR_WIDTH-1:0] dataarray_data_V_readaddr,
  output logic [DATA_WIDTH-1:0] dataarray_data_V_dout,
  output logic [7:0]            nentries_0_V_dout,
  output logic [7:0]            nentries_1_V_dout,
  output logic                  count_err
);

  localparam int PAGE_BITS = $clog2(NUM_PAGES);

  // Storage and read path
  logic [DATA_WIDTH-1:0] mem [NUM_PAGES*PAGE_DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;

  // Reset wins over a simultaneous write. RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && dataarray_data_V_wea) begin
      mem[dataarray_data_V_writeaddr] <= dataarray_data_V_din;
    end
  end

  // The nonblocking read returns the pre-write contents on a same-address
  // collision, which gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else if (dataarray_data_V_enb) begin
      rd_q <= mem[dataarray_data_V_readaddr];
    end
  end

`ifdef VMPROJ_MEM_OUTREG_EN
  logic [DATA_WIDTH-1:0] out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= rd_q;
    end
  end

  assign dataarray_data_V_dout = out_q;
`else
  assign dataarray_data_V_dout = rd_q;
`endif

  // Per-page write counters and committed entry counts
  logic [NUM_PAGES-1:0] cnt_we;
  logic [7:0]           cnt_din    [NUM_PAGES];
  logic [7:0]           wrcnt      [NUM_PAGES];
  logic [7:0]           wrcnt_next [NUM_PAGES];
  logic [7:0]           nent_q     [NUM_PAGES];
  logic [NUM_PAGES-1:0] mismatch;
  logic [PAGE_BITS-1:0] wr_page;
  logic                 err_q;

  assign cnt_we     = {nentries_1_V_we, nentries_0_V_we};
  assign cnt_din[0] = nentries_0_V_din;
  assign cnt_din[1] = nentries_1_V_din;
  assign wr_page    = dataarray_data_V_writeaddr[ADDR_WIDTH-1 -: PAGE_BITS];

  // wrcnt_next includes a write landing in this cycle. A commit in the same
  // cycle therefore compares against a count that already includes that write.
  always_comb begin
    for (int n = 0; n < NUM_PAGES; n++) begin
      wrcnt_next[n] = wrcnt[n];
      if (dataarray_data_V_wea && (wr_page == PAGE_BITS'(n)) && (wrcnt[n] != 8'hFF)) begin
        wrcnt_next[n] = wrcnt[n] + 8'd1;
      end
      mismatch[n] = cnt_we[n] && (cnt_din[n] != wrcnt_next[n]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_PAGES; n++) begin
        wrcnt[n]  <= 8'd0;
        nent_q[n] <= 8'd0;
      end
      err_q <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_PAGES; n++) begin
        // A commit closes the page: the counter restarts from zero.
        wrcnt[n] <= cnt_we[n] ? 8'd0 : wrcnt_next[n];
        if (cnt_we[n]) begin
          nent_q[n] <= cnt_din[n];
        end
      end
      if (|mismatch) begin
        err_q <= 1'b1;
      end
    end
  end

  assign nentries_0_V_dout = nent_q[0];
  assign nentries_1_V_dout = nent_q[1];
  assign count_err         = err_q;

endmodule

// File: tb/tb_vmproj_page_mem.sv
// tb/tb_vmproj_page_mem.sv - self-checking bench for vmproj_page_mem against a behavioural model

module tb_vmproj_page_mem;

`ifdef VMPROJ_MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        dataarray_data_V_wea;
  logic [7:0]  dataarray_data_V_writeaddr;
  logic [20:0] dataarray_data_V_din;
  logic        nentries_0_V_we;
  logic [7:0]  nentries_0_V_din;
  logic        nentries_1_V_we;
  logic [7:0]  nentries_1_V_din;
  logic        dataarray_data_V_enb;
  logic [7:0]  dataarray_data_V_readaddr;
  logic [20:0] dataarray_data_V_dout;
  logic [7:0]  nentries_0_V_dout;
  logic [7:0]  nentries_1_V_dout;
  logic        count_err;

  int checks   = 0;
  int failures = 0;

  vmproj_page_mem dut (
    .clk                        (clk),
    .reset                      (reset),
    .dataarray_data_V_wea       (dataarray_data_V_wea),
    .dataarray_data_V_writeaddr (dataarray_data_V_writeaddr),
    .dataarray_data_V_din       (dataarray_data_V_din),
    .nentries_0_V_we            (nentries_0_V_we),
    .nentries_0_V_din           (nentries_0_V_din),
    .nentries_1_V_we            (nentries_1_V_we),
    .nentries_1_V_din           (nentries_1_V_din),
    .dataarray_data_V_enb       (dataarray_data_V_enb),
    .dataarray_data_V_readaddr  (dataarray_data_V_readaddr),
    .dataarray_data_V_dout      (dataarray_data_V_dout),
    .nentries_0_V_dout          (nentries_0_V_dout),
    .nentries_1_V_dout          (nentries_1_V_dout),
    .count_err                  (count_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: memory image, per-page word counts, committed counts,
  // sticky error, and the read pipeline with a "known" flag per stage.
  logic [20:0] m_mem [256];
  bit          m_wr  [256];
  int          m_cnt [2];
  logic [7:0]  m_nent [2];
  bit          m_err;
  logic [20:0] m_dout, m_stage;
  bit          m_dout_k, m_stage_k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_count(input int p);
    int c;
    c = m_cnt[p];
    if (dataarray_data_V_wea && (int'(dataarray_data_V_writeaddr) / 128 == p) && c < 255) c++;
    return 8'(c);
  endfunction

  // One clock: capture driven inputs, advance the model, then compare outputs.
  task automatic cycle();
    bit          r, wea, enb;
    bit          we [2];
    logic [7:0]  wa, ra;
    logic [7:0]  nd [2];
    logic [20:0] din, rv;
    bit          rk;
    int          p;
    r = reset; wea = dataarray_data_V_wea; enb = dataarray_data_V_enb;
    wa = dataarray_data_V_writeaddr; ra = dataarray_data_V_readaddr;
    din = dataarray_data_V_din;
    we[0] = nentries_0_V_we; we[1] = nentries_1_V_we;
    nd[0] = nentries_0_V_din; nd[1] = nentries_1_V_din;
    @(posedge clk);
    #1;
    if (r) begin
      for (int q = 0; q < 2; q++) begin m_cnt[q] = 0; m_nent[q] = 8'd0; end
      m_err = 1'b0;
      m_dout = '0; m_dout_k = 1'b1;
      m_stage = '0; m_stage_k = 1'b1;
    end else begin
      if (enb) begin rv = m_mem[ra]; rk = m_wr[ra]; end
      else if (LAT == 1) begin rv = m_dout; rk = m_dout_k; end
      else begin rv = m_stage; rk = m_stage_k; end
      if (LAT == 1) begin
        m_dout = rv; m_dout_k = rk;
      end else begin
        m_dout = m_stage; m_dout_k = m_stage_k;
        m_stage = rv; m_stage_k = rk;
      end
      if (wea) begin
        m_mem[wa] = din; m_wr[wa] = 1'b1;
        p = int'(wa) / 128;
        if (m_cnt[p] < 255) m_cnt[p]++;
      end
      for (int q = 0; q < 2; q++) begin
        if (we[q]) begin
          if (int'(nd[q]) != m_cnt[q]) m_err = 1'b1;
          m_cnt[q] = 0;
          m_nent[q] = nd[q];
        end
      end
    end
    if (m_dout_k) chk("dout", 32'(dataarray_data_V_dout), 32'(m_dout));
    chk("nent0", 32'(nentries_0_V_dout), 32'(m_nent[0]));
    chk("nent1", 32'(nentries_1_V_dout), 32'(m_nent[1]));
    chk("count_err", 32'(count_err), 32'(m_err));
  endtask

  task automatic idle();
    dataarray_data_V_wea = 1'b0; dataarray_data_V_enb = 1'b0;
    nentries_0_V_we = 1'b0; nentries_1_V_we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [20:0] d);
    idle();
    dataarray_data_V_wea = 1'b1; dataarray_data_V_writeaddr = a; dataarray_data_V_din = d;
    cycle();
  endtask

  task automatic rd(input logic [7:0] a);
    idle();
    dataarray_data_V_enb = 1'b1; dataarray_data_V_readaddr = a;
    cycle();
    idle();
    repeat (LAT - 1) cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin m_mem[i] = '0; m_wr[i] = 1'b0; end
    m_cnt[0] = 0; m_cnt[1] = 0; m_nent[0] = 8'd0; m_nent[1] = 8'd0;
    m_err = 1'b0; m_dout = '0; m_stage = '0; m_dout_k = 1'b0; m_stage_k = 1'b0;
    idle();
    dataarray_data_V_writeaddr = '0; dataarray_data_V_readaddr = '0;
    dataarray_data_V_din = '0; nentries_0_V_din = '0; nentries_1_V_din = '0;

    // Reset state
    reset = 1'b1;
    cycle(); cycle();
    chk("reset_dout", 32'(dataarray_data_V_dout), 32'h0);
    chk("reset_err", 32'(count_err), 32'h0);
    reset = 1'b0;

    // Basic write then read
    wr(8'h05, 21'h1ABCD);
    rd(8'h05);
    chk("req034_dout", 32'(dataarray_data_V_dout), 32'h1ABCD);

    // Page 1 commit with the correct count
    wr(8'h80, 21'h00111); wr(8'h81, 21'h00222); wr(8'h82, 21'h00333);
    idle(); nentries_1_V_we = 1'b1; nentries_1_V_din = 8'd3; cycle();
    idle(); cycle();
    chk("req035_nent1", 32'(nentries_1_V_dout), 32'd3);
    chk("req035_err", 32'(count_err), 32'd0);

    // Read-first collision
    wr(8'h10, 21'h00011);
    idle();
    dataarray_data_V_wea = 1'b1; dataarray_data_V_writeaddr = 8'h10; dataarray_data_V_din = 21'h00022;
    dataarray_data_V_enb = 1'b1; dataarray_data_V_readaddr = 8'h10;
    cycle();
    idle(); repeat (LAT - 1) cycle();
    chk("req037_old", 32'(dataarray_data_V_dout), 32'h00011);
    rd(8'h10);
    chk("req037_new", 32'(dataarray_data_V_dout), 32'h00022);

    // Close page 0 correctly (0x05, 0x10, 0x10 = 3 writes), with a same-cycle write
    idle(); nentries_0_V_we = 1'b1; nentries_0_V_din = 8'd4;
    dataarray_data_V_wea = 1'b1; dataarray_data_V_writeaddr = 8'h11; dataarray_data_V_din = 21'h0ABCD;
    cycle();
    chk("req023_err", 32'(count_err), 32'd0);
    chk("req023_nent0", 32'(nentries_0_V_dout), 32'd4);

    // Count mismatch on page 0 is sticky
    wr(8'h20, 21'h00001); wr(8'h21, 21'h00002);
    idle(); nentries_0_V_we = 1'b1; nentries_0_V_din = 8'd5; cycle();
    chk("req036_err", 32'(count_err), 32'd1);
    idle(); nentries_0_V_we = 1'b1; nentries_0_V_din = 8'd0; cycle();
    idle(); repeat (3) cycle();
    chk("req036_sticky", 32'(count_err), 32'd1);

    // Reset mid-read with a simultaneous write that must be dropped
    idle();
    reset = 1'b1;
    dataarray_data_V_enb = 1'b1; dataarray_data_V_readaddr = 8'h81;
    dataarray_data_V_wea = 1'b1; dataarray_data_V_writeaddr = 8'h80; dataarray_data_V_din = 21'h1FFFF;
    cycle();
    chk("req038_dout", 32'(dataarray_data_V_dout), 32'h0);
    chk("req038_nent1", 32'(nentries_1_V_dout), 32'h0);
    chk("req038_err", 32'(count_err), 32'h0);
    // Read issued as reset deasserts completes normally
    reset = 1'b0;
    rd(8'h80);
    chk("req038_read", 32'(dataarray_data_V_dout), 32'h00111);

    // Randomized traffic with mostly-correct commits
    for (int i = 0; i < 300; i++) begin
      dataarray_data_V_wea = 1'($urandom);
      dataarray_data_V_writeaddr = {1'($urandom), 2'b00, 5'($urandom)};
      dataarray_data_V_din = 21'($urandom);
      dataarray_data_V_enb = 1'($urandom);
      dataarray_data_V_readaddr = {1'($urandom), 2'b00, 5'($urandom)};
      nentries_0_V_we = ($urandom_range(0, 15) == 0);
      nentries_1_V_we = ($urandom_range(0, 15) == 0);
      nentries_0_V_din = exp_count(0);
      nentries_1_V_din = exp_count(1);
      cycle();
    end
    chk("rand_err", 32'(count_err), 32'd0);

    // Close both pages, then saturate page 1's counter
    idle();
    nentries_0_V_we = 1'b1; nentries_0_V_din = exp_count(0);
    nentries_1_V_we = 1'b1; nentries_1_V_din = exp_count(1);
    cycle();
    for (int i = 0; i < 260; i++) wr(8'h80 + 8'(i % 128), 21'(i));
    idle(); nentries_1_V_we = 1'b1; nentries_1_V_din = 8'd255; cycle();
    chk("sat_nent1", 32'(nentries_1_V_dout), 32'd255);
    chk("sat_err", 32'(count_err), 32'd0);

    // Independent commits on both pages in one cycle
    idle();
    nentries_0_V_we = 1'b1; nentries_0_V_din = 8'd7;
    nentries_1_V_we = 1'b1; nentries_1_V_din = 8'd0;
    cycle();
    chk("req024_nent0", 32'(nentries_0_V_dout), 32'd7);
    chk("req024_nent1", 32'(nentries_1_V_dout), 32'd0);
    chk("req024_err", 32'(count_err), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
